// File: rtl/gpio_pkg.sv
// Shared register map and helpers for the GPIO controller.
// Used by gpio_ctrl and gpio_sync.
package gpio_pkg;

  typedef enum logic [2:0] {
    GPIO_REG_OUT     = 3'd0,
    GPIO_REG_OE      = 3'd1,
    GPIO_REG_IN      = 3'd2,
    GPIO_REG_RISE_EN = 3'd3,
    GPIO_REG_FALL_EN = 3'd4,
    GPIO_REG_PEND    = 3'd5,
    GPIO_REG_OUT_SET = 3'd6,
    GPIO_REG_OUT_CLR = 3'd7
  } gpio_reg_e;

  localparam int unsigned GPIO_ADDR_W = 3;

  // Counter width able to hold DEBOUNCE_CYCLES-1; never narrower than one bit.
  function automatic int unsigned gpio_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop pad input synchronizer with an optional per-pin debounce stage,
// compiled in when GPIO_CTRL_DEBOUNCE_EN is defined.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int NPINS           = 20,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPINS-1:0] pad_i,
  output logic [NPINS-1:0] in_o
);

  logic [NPINS-1:0] meta_q, meta_d;
  logic [NPINS-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = pad_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

`ifdef GPIO_CTRL_DEBOUNCE_EN
  localparam int unsigned CNT_W = gpio_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [NPINS];
  logic [CNT_W-1:0] cnt_d [NPINS];
  logic [NPINS-1:0] stable_q, stable_d;

  // A pin's counter only runs while the synchronized value disagrees with the
  // accepted value; any agreement (a bounce back) restarts it from zero.
  always_comb begin
    stable_d = stable_q;
    for (int n = 0; n < NPINS; n++) begin
      cnt_d[n] = '0;
      if (sync_q[n] != stable_q[n]) begin
        if (cnt_q[n] == CNT_MAX) begin
          stable_d[n] = sync_q[n];
        end else begin
          cnt_d[n] = cnt_q[n] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      for (int n = 0; n < NPINS; n++) cnt_q[n] <= '0;
    end else begin
      stable_q <= stable_d;
      for (int n = 0; n < NPINS; n++) cnt_q[n] <= cnt_d[n];
    end
  end

  assign in_o = stable_q;
`else
  assign in_o = sync_q;
`endif

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller: output/enable registers, synchronized inputs, edge-triggered
// pending bits with level irq. Optional input debounce via GPIO_CTRL_DEBOUNCE_EN.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int NPINS           = 20,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       bus_addr,
  input  logic [NPINS-1:0] bus_wdata,
  input  logic             bus_we,
  input  logic             bus_re,
  output logic [NPINS-1:0] bus_rdata,
  output logic             bus_rvalid,
  output logic [NPINS-1:0] pad_o,
  output logic [NPINS-1:0] pad_oe,
  input  logic [NPINS-1:0] pad_i,
  output logic             irq
);

  logic [NPINS-1:0] in_val;

  logic [NPINS-1:0] out_q, out_d;
  logic [NPINS-1:0] oe_q, oe_d;
  logic [NPINS-1:0] rise_en_q, rise_en_d;
  logic [NPINS-1:0] fall_en_q, fall_en_d;
  logic [NPINS-1:0] pend_q, pend_d;
  logic [NPINS-1:0] prev_q, prev_d;
  logic [NPINS-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             irq_q, irq_d;

  logic [NPINS-1:0] rise_evt, fall_evt, set_evt, pend_clr;

  gpio_sync #(
    .NPINS           (NPINS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .pad_i (pad_i),
    .in_o  (in_val)
  );

  always_comb begin
    prev_d   = in_val;
    rise_evt = in_val & ~prev_q;
    fall_evt = ~in_val & prev_q;
    set_evt  = (rise_evt & rise_en_q) | (fall_evt & fall_en_q);

    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    pend_clr  = '0;

    if (bus_we) begin
      case (bus_addr)
        GPIO_REG_OUT:     out_d     = bus_wdata;
        GPIO_REG_OE:      oe_d      = bus_wdata;
        GPIO_REG_RISE_EN: rise_en_d = bus_wdata;
        GPIO_REG_FALL_EN: fall_en_d = bus_wdata;
        GPIO_REG_PEND:    pend_clr  = bus_wdata;
        GPIO_REG_OUT_SET: out_d     = out_q | bus_wdata;
        GPIO_REG_OUT_CLR: out_d     = out_q & ~bus_wdata;
        default:          ;
      endcase
    end

    // Set wins over a same-cycle write-1-to-clear of the same bit.
    pend_d = (pend_q & ~pend_clr) | set_evt;
    irq_d  = |pend_q;

    // Reads see the registers as they stand before any same-cycle write.
    rvalid_d = bus_re;
    rdata_d  = '0;
    if (bus_re) begin
      case (bus_addr)
        GPIO_REG_OUT:     rdata_d = out_q;
        GPIO_REG_OE:      rdata_d = oe_q;
        GPIO_REG_IN:      rdata_d = in_val;
        GPIO_REG_RISE_EN: rdata_d = rise_en_q;
        GPIO_REG_FALL_EN: rdata_d = fall_en_q;
        GPIO_REG_PEND:    rdata_d = pend_q;
        default:          rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      prev_q    <= prev_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      irq_q     <= irq_d;
    end
  end

  assign pad_o      = out_q;
  assign pad_oe     = oe_q;
  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 SHALL have parameter NPINS, default 20, number of pad bits driven into and read from iobank0.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable-sample count required when debounce is compiled in.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port bus_addr  input  3  word register index.
REQ-006 SHALL have ports bus_wdata  input  NPINS, bus_we  input  1, bus_re  input  1  register write data, write strobe and read strobe.
REQ-007 SHALL have ports bus_rdata  output  NPINS and bus_rvalid  output  1  read data and its valid flag.
REQ-008 SHALL have ports pad_o  output  NPINS and pad_oe  output  NPINS  per-pin output value and output enable to the pad bank.
REQ-009 SHALL have port pad_i  input  NPINS  raw, asynchronous pad input from the pad bank.
REQ-010 SHALL have port irq  output  1  level interrupt.

Function
REQ-011 SHALL decode registers: 0 OUT (rw), 1 OE (rw), 2 IN (ro), 3 RISE_EN (rw), 4 FALL_EN (rw), 5 PEND (read; write-1-to-clear), 6 OUT_SET (write-1-to-set OUT; reads 0), 7 OUT_CLR (write-1-to-clear OUT; reads 0).
REQ-012 SHALL drive pad_o from OUT and pad_oe from OE directly from registers, with the new value visible the cycle after bus_we.
REQ-013 SHALL pass pad_i through a 2-flop synchronizer; IN SHALL reflect a pad change 2 cycles after it is sampled.
REQ-014 SHALL detect a rising edge on bit n as sync_prev[n]=0 and sync[n]=1, and a falling edge as the inverse, both one cycle after IN changes.
REQ-015 SHALL set PEND[n] on a detected edge whose RISE_EN[n] or FALL_EN[n] bit is set; disabled edges SHALL be dropped, not latched.
REQ-016 SHALL give set priority when an edge event and a PEND clear of the same bit coincide, so the bit remains 1.
REQ-017 SHALL drive irq as the registered OR of PEND, one cycle after PEND changes.
REQ-018 SHALL return read data on bus_rdata with bus_rvalid high exactly one cycle after bus_re, and bus_rvalid SHALL be a 1-cycle pulse per strobe.
REQ-019 SHALL return the pre-write register value when bus_re and bus_we hit the same address in the same cycle.
REQ-020 SHALL hold bus_rdata at 0 when bus_rvalid is low.
REQ-021 SHALL make OUT_SET and OUT_CLR writes affect only bits written as 1.

Reset
REQ-022 SHALL, while rst is high at a clock edge, clear OUT, OE, RISE_EN, FALL_EN, PEND, synchronizer flops, bus_rdata, bus_rvalid and irq to 0; all pads become inputs.
REQ-023 SHALL drop a read in flight when rst is asserted: no bus_rvalid after reset, and no spurious edge after release.

Configuration
REQ-024 SHALL compile a per-pin debounce stage after the synchronizer when macro GPIO_CTRL_DEBOUNCE_EN is defined: IN[n] updates only after sync[n] has differed from IN[n] for DEBOUNCE_CYCLES consecutive cycles, and the counter restarts on any bounce.
REQ-025 SHALL, without GPIO_CTRL_DEBOUNCE_EN, feed the synchronizer output straight to IN with no counters instantiated.

Structure
REQ-026 SHALL place register index constants (GPIO_REG_OUT..GPIO_REG_OUT_CLR) in shared package gpio_pkg.
REQ-027 SHALL implement the synchronizer and the optional debounce as one sub-module gpio_sync, parameterized by NPINS and DEBOUNCE_CYCLES.

Verification
REQ-028 SHALL verify that writing OE=0x000FF, then OUT=0x00055, gives pad_oe=0x000FF and pad_o=0x00055 the next cycle, then OUT_SET=0x00100 gives pad_o=0x00155 and OUT_CLR=0x00001 gives pad_o=0x00154.
REQ-029 SHALL verify that with RISE_EN=0x00004, driving pad_i[2] 0->1 sets PEND=0x00004 and irq=1 within 4 cycles, and a falling edge then leaves PEND unchanged.
REQ-030 SHALL verify that writing PEND=0x00004 in the same cycle as a new enabled edge on bit 2 keeps PEND=0x00004, and a later clear with no edge gives PEND=0 and irq=0.
REQ-031 SHALL verify that bus_re on IN with pad_i=0xABCDE held for 3 cycles gives bus_rvalid for exactly 1 cycle with bus_rdata=0xABCDE.
REQ-032 SHALL verify that, with GPIO_CTRL_DEBOUNCE_EN, a pulse of 15 cycles on pad_i[0] leaves IN[0]=0, while a pulse of 16 cycles updates IN[0] to 1.
REQ-033 SHALL verify that asserting rst mid-read with OUT=0xFFFFF gives pad_o=0, pad_oe=0, irq=0 and no bus_rvalid the following cycle.
